// File: rtl/rvvi_rx_cmd_decoder.sv
// Receive-side command decoder for the RVVI tracer: parses MAC RX frames into trigger / slow-down pulses.
// Optional frame statistics counters are built when RVVI_RX_STATS_EN is defined.
module rvvi_rx_cmd_decoder #(
  parameter logic [47:0] DST_MAC    = 48'h4502_1111_6843,
  parameter logic [47:0] SRC_MAC    = 48'h8f54_0000_1654,
  parameter logic [15:0] ETHER_TYPE = 16'h005c,
  parameter logic [47:0] TRIG_CMD   = 48'h7274_6e69_6769,
  parameter logic [47:0] SLOW_CMD   = 48'h6c73_656d_776f
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic [31:0] RvviAxiRdata,
  input  logic [3:0]  RvviAxiRstrb,
  input  logic        RvviAxiRlast,
  input  logic        RvviAxiRvalid,
  output logic        IlaTrigger,
  output logic        HostRequestSlowDown,
  output logic [31:0] HostFiFoFillAmt,
  output logic [15:0] FramesOk,
  output logic [15:0] FramesDropped
);

  typedef enum logic [0:0] {ST_HDR = 1'b0, ST_DROP = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic [47:0] cmd_r, cmd_nxt_s, cmd_full_s;
  logic [31:0] arg_r, arg_nxt_s;
  logic [31:0] fill_r, fill_nxt_s;
  logic        trig_r, trig_nxt_s;
  logic        slow_r, slow_nxt_s;
  logic        bad_s, ok_inc_s, drop_inc_s;

  // Command as seen at this beat: at w4 the low half comes straight off the bus.
  assign cmd_full_s = (cnt_r == 3'd4) ? {cmd_r[47:32], RvviAxiRdata} : cmd_r;

  // Header compare for the current word position.
  always_comb begin
    bad_s = 1'b0;
    case (cnt_r)
      3'd0:    bad_s = (RvviAxiRdata != DST_MAC[31:0]);
      3'd1:    bad_s = (RvviAxiRdata != {SRC_MAC[15:0], DST_MAC[47:32]});
      3'd2:    bad_s = (RvviAxiRdata != SRC_MAC[47:16]);
      3'd3:    bad_s = (RvviAxiRdata[15:0] != ETHER_TYPE);
      3'd4:    bad_s = (cmd_full_s != TRIG_CMD) && (cmd_full_s != SLOW_CMD);
      default: bad_s = 1'b0;
    endcase
    if ((cnt_r <= 3'd5) && (RvviAxiRstrb != 4'hF)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = bad_s;
    end
  end

  // Frame parser next-state and output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cmd_nxt_s   = cmd_r;
    arg_nxt_s   = arg_r;
    fill_nxt_s  = fill_r;
    trig_nxt_s  = 1'b0;
    slow_nxt_s  = 1'b0;
    ok_inc_s    = 1'b0;
    drop_inc_s  = 1'b0;
    if (RvviAxiRvalid) begin
      case (state_r)
        ST_DROP: begin
          if (RvviAxiRlast) begin
            state_nxt_s = ST_HDR;
            cnt_nxt_s   = 3'd0;
            drop_inc_s  = 1'b1;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        ST_HDR: begin
          if (bad_s) begin
            cnt_nxt_s = 3'd0;
            if (RvviAxiRlast) begin
              drop_inc_s = 1'b1;
            end else begin
              state_nxt_s = ST_DROP;
            end
          end else begin
            if (cnt_r == 3'd3) begin
              cmd_nxt_s[47:32] = RvviAxiRdata[31:16];
            end else if (cnt_r == 3'd4) begin
              cmd_nxt_s = cmd_full_s;
            end else if (cnt_r == 3'd5) begin
              arg_nxt_s = RvviAxiRdata;
            end else begin
              cmd_nxt_s = cmd_r;
            end
            if (RvviAxiRlast) begin
              cnt_nxt_s = 3'd0;
              if ((cnt_r >= 3'd4) && (cmd_full_s == TRIG_CMD)) begin
                trig_nxt_s = 1'b1;
                ok_inc_s   = 1'b1;
              end else if ((cnt_r >= 3'd5) && (cmd_full_s == SLOW_CMD)) begin
                slow_nxt_s = 1'b1;
                ok_inc_s   = 1'b1;
                fill_nxt_s = (cnt_r == 3'd5) ? RvviAxiRdata : arg_r;
              end else begin
                drop_inc_s = 1'b1;
              end
            end else begin
              cnt_nxt_s = (cnt_r == 3'd6) ? 3'd6 : cnt_r + 3'd1;
            end
          end
        end
        default: begin
          state_nxt_s = ST_HDR;
          cnt_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_r <= ST_HDR;
      cnt_r   <= 3'd0;
      cmd_r   <= 48'h0;
      arg_r   <= 32'h0;
      fill_r  <= 32'h0;
      trig_r  <= 1'b0;
      slow_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cmd_r   <= cmd_nxt_s;
      arg_r   <= arg_nxt_s;
      fill_r  <= fill_nxt_s;
      trig_r  <= trig_nxt_s;
      slow_r  <= slow_nxt_s;
    end
  end

  assign IlaTrigger          = trig_r;
  assign HostRequestSlowDown = slow_r;
  assign HostFiFoFillAmt     = fill_r;

`ifdef RVVI_RX_STATS_EN
  logic [15:0] ok_cnt_r, drop_cnt_r;

  // Saturating frame statistics.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      ok_cnt_r   <= 16'h0;
      drop_cnt_r <= 16'h0;
    end else begin
      if (ok_inc_s && (ok_cnt_r != 16'hFFFF)) begin
        ok_cnt_r <= ok_cnt_r + 16'h1;
      end else begin
        ok_cnt_r <= ok_cnt_r;
      end
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign FramesOk      = ok_cnt_r;
  assign FramesDropped = drop_cnt_r;
`else
  logic stats_unused_s;
  assign stats_unused_s = ok_inc_s ^ drop_inc_s;
  assign FramesOk       = 16'h0;
  assign FramesDropped  = 16'h0;
`endif

endmodule

// File: tb/tb_rvvi_rx_cmd_decoder.sv
// Table-driven bench for rvvi_rx_cmd_decoder, plus hand-written reset and counter-saturation sequences.
module tb_rvvi_rx_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [3:0]  rstrb = 4'h0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        trig, slow;
  logic [31:0] fill;
  logic [15:0] frames_ok, frames_dropped;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        v;
    logic        t;
    logic        sl;
    logic [31:0] f;
    logic [15:0] ok;
    logic [15:0] dr;
  } vec_t;

  vec_t vq[$];
  logic [31:0] ef;
  logic [15:0] eo, ed;

  rvvi_rx_cmd_decoder dut (
    .m_axi_aclk         (clk),
    .m_axi_aresetn      (rst_n),
    .RvviAxiRdata       (rdata),
    .RvviAxiRstrb       (rstrb),
    .RvviAxiRlast       (rlast),
    .RvviAxiRvalid      (rvalid),
    .IlaTrigger         (trig),
    .HostRequestSlowDown(slow),
    .HostFiFoFillAmt    (fill),
    .FramesOk           (frames_ok),
    .FramesDropped      (frames_dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sx(input logic [15:0] v);
`ifdef RVVI_RX_STATS_EN
    return v;
`else
    return 16'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic t, input logic sl, input logic [31:0] f,
                         input logic [15:0] ok, input logic [15:0] dr);
    chk({tag, " trig"}, {31'h0, trig}, {31'h0, t});
    chk({tag, " slow"}, {31'h0, slow}, {31'h0, sl});
    chk({tag, " fill"}, fill, f);
    chk({tag, " ok"}, {16'h0, frames_ok}, {16'h0, sx(ok)});
    chk({tag, " dropped"}, {16'h0, frames_dropped}, {16'h0, sx(dr)});
  endtask

  task automatic add(input logic [31:0] d, input logic [3:0] s, input logic l, input logic v,
                     input logic t, input logic sl);
    vec_t x;
    x.d = d; x.s = s; x.l = l; x.v = v; x.t = t; x.sl = sl;
    x.f = ef; x.ok = eo; x.dr = ed;
    vq.push_back(x);
  endtask

  task automatic hdr3();
    add(32'h1111_6843, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h1654_4502, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h8f54_0000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic v);
    @(negedge clk);
    rdata = d; rstrb = s; rlast = l; rvalid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ef = 32'h0; eo = 16'h0; ed = 16'h0;
    // trigger frame, last on w5
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd1;
    add(32'h0000_0000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    // slow frame with an idle gap (carrying junk and last) before w4
    hdr3();
    add(32'h6c73_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'hdead_beef, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(32'h656d_776f, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd2; ef = 32'h0000_0200;
    add(32'h0000_0200, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    // truncated slow frame, last on w4
    hdr3();
    add(32'h6c73_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    ed = 16'd1;
    add(32'h656d_776f, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    // wrong EtherType in a 10-beat frame, then trigger frame back-to-back
    hdr3();
    add(32'h7274_0800, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h1111_6843, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h1654_4502, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h8f54_0000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    ed = 16'd2;
    add(32'h6e69_6769, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd3;
    add(32'h0000_0001, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    // strobe 4'h7 on w2
    add(32'h1111_6843, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h1654_4502, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h8f54_0000, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    ed = 16'd3;
    add(32'h0000_0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    // trigger with last on w4, then slow frame immediately after
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd4;
    add(32'h6e69_6769, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    hdr3();
    add(32'h6c73_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h656d_776f, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd5; ef = 32'h0000_0345;
    add(32'h0000_0345, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    // long trigger frame, tail beats with bad strobes are ignored
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h0000_0077, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'hffff_ffff, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd6;
    add(32'h1234_5678, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    // long slow frame: fill comes from the w5 shadow, not the last beat
    hdr3();
    add(32'h6c73_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h656d_776f, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h0000_0999, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd7; ef = 32'h0000_0999;
    add(32'haaaa_5555, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    // unknown cmd at w4 with last, then a trigger frame right after
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    ed = 16'd4;
    add(32'h6e69_0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    hdr3();
    add(32'h7274_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h6e69_6769, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    eo = 16'd8;
    add(32'h0000_0000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    // single-beat mismatching frame
    ed = 16'd5;
    add(32'h0000_0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    // slow frame with partial strobe on w5
    hdr3();
    add(32'h6c73_005c, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    add(32'h656d_776f, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    ed = 16'd6;
    add(32'h0000_0111, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);

    #12;
    chk_all("reset", 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      beat(vq[i].d, vq[i].s, vq[i].l, vq[i].v);
      chk_all($sformatf("vec%0d", i), vq[i].t, vq[i].sl, vq[i].f, vq[i].ok, vq[i].dr);
    end

    // reset pulsed at w2 of a trigger frame; the tail is dropped
    beat(32'h1111_6843, 4'hF, 1'b0, 1'b1);
    beat(32'h1654_4502, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    rdata = 32'h8f54_0000; rstrb = 4'hF; rlast = 1'b0; rvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 1'b0, 1'b0, 32'h0, 16'h0, 16'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(32'h7274_005c, 4'hF, 1'b0, 1'b1);
    beat(32'h6e69_6769, 4'hF, 1'b0, 1'b1);
    beat(32'h0000_0000, 4'hF, 1'b1, 1'b1);
    chk_all("tail", 1'b0, 1'b0, 32'h0, 16'h0, 16'h1);
    beat(32'h0000_0000, 4'hF, 1'b0, 1'b0);
    chk_all("tail_idle", 1'b0, 1'b0, 32'h0, 16'h0, 16'h1);

`ifdef RVVI_RX_STATS_EN
    // 65540 single-beat dropped frames saturate the counter
    for (int k = 0; k < 65540; k++) begin
      @(negedge clk);
      rdata = 32'h0; rstrb = 4'hF; rlast = 1'b1; rvalid = 1'b1;
    end
    beat(32'h0000_0000, 4'hF, 1'b0, 1'b0);
    chk("saturate dropped", {16'h0, frames_dropped}, 32'h0000_FFFF);
    chk("saturate ok", {16'h0, frames_ok}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
